divider16: RTL and testbench

- Sequential restoring divider: 16-bit dividend by 8-bit divisor, giving an 8-bit quotient and an 8-bit remainder.
- Inverse companion of the 8x8 shift-add multiplier datapath; sits beside it in the arithmetic block.
- Uses the same start/done control style. Produces one quotient bit per clock.

---
 rtl/divider16_pkg.sv | 14 +
 rtl/divider16_div_step.sv | 24 ++
 rtl/divider16.sv | 113 +++++++++++
 tb/tb_divider16.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/divider16_pkg.sv
// Shared definitions for the restoring divider: state encoding, default width,
// and the quotient value reported on divide-by-zero / overflow.
package divider16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned WIDTH_DEF = 8;
  localparam logic [7:0]  ERR_QUOT  = 8'hFF;

endpackage

// File: rtl/divider16_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational, no latency, no flow control.
module div_step #(
  parameter int unsigned WIDTH = divider16_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] pr_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] pr_o,
  output logic             q_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // pr_i < div_i is guaranteed by the caller, so the difference always fits WIDTH bits.
  always_comb begin
    trial = {pr_i, bit_i};
    diff  = trial - {1'b0, div_i};
    q_o   = (trial >= {1'b0, div_i});
    pr_o  = q_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/divider16.sv
// Sequential 2W/W restoring divider, one quotient bit per clock: done 9 edges after start (1 on error).
// st is accepted only in IDLE; st and operand changes are ignored while busy.
module divider16
  import divider16_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st,
  input  logic [2*WIDTH-1:0] a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic               err
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pr_q, pr_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] step_pr;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .pr_i  (pr_q),
    .bit_i (dq_q[WIDTH-1]),
    .div_i (b_q),
    .pr_o  (step_pr),
    .q_o   (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    dq_d    = dq_q;
    b_d     = b_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (st) begin
          b_d   = b;
          err_d = 1'b0;
          // A zero divisor or a high half >= divisor would need more than WIDTH quotient bits.
          if (b == '0 || a[2*WIDTH-1:WIDTH] >= b) begin
            state_d = DONE;
            quot_d  = WIDTH'(ERR_QUOT);
            rem_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = CALC;
            pr_d    = a[2*WIDTH-1:WIDTH];
            dq_d    = a[WIDTH-1:0];
            cnt_d   = CNT_W'(WIDTH - 1);
          end
        end
      end
      CALC: begin
        pr_d = step_pr;
        dq_d = {dq_q[WIDTH-2:0], step_q};
        if (cnt_q == '0) begin
          quot_d  = dq_d;
          rem_d   = step_pr;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      dq_q    <= '0;
      b_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      dq_q    <= dq_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign err       = err_q;
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_divider16.sv
// Randomised and directed checks of divider16 against plain integer division.
module tb_divider16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st  = 1'b0;
  logic [15:0] a   = '0;
  logic [7:0]  b   = '0;
  logic [7:0]  quotient, remainder;
  logic        busy, done, err;

  int total = 0;
  int bad   = 0;

  divider16 #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .st        (st),
    .a         (a),
    .b         (b),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Starts a division and waits (bounded) for done; lat counts edges from the start edge.
  task automatic run_div(input logic [15:0] av, input logic [7:0] bv,
                         output int lat, output int bcnt);
    @(negedge clk);
    a  = av;
    b  = bv;
    st = 1'b1;
    @(posedge clk); #1;
    st   = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy) bcnt++;
  endtask

  task automatic div_and_check(input logic [15:0] av, input logic [7:0] bv, input bit full);
    int lat, bc;
    int exp_q, exp_r;
    bit exp_e;
    if (bv == 0)                  exp_e = 1'b1;
    else if (int'(av) / int'(bv) > 255) exp_e = 1'b1;
    else                          exp_e = 1'b0;
    if (exp_e) begin
      exp_q = 8'hFF;
      exp_r = 0;
    end else begin
      exp_q = int'(av) / int'(bv);
      exp_r = int'(av) % int'(bv);
    end
    run_div(av, bv, lat, bc);
    chk("latency", lat, exp_e ? 1 : 9);
    chk("quotient", {24'b0, quotient}, exp_q);
    chk("remainder", {24'b0, remainder}, exp_r);
    chk("err", {31'b0, err}, {31'b0, exp_e});
    if (full) chk("busy_cycles", bc, exp_e ? 1 : 9);
    if (!exp_e) begin
      chk("invariant", int'(quotient) * int'(bv) + int'(remainder), av);
      chk("rem_lt_b", {31'b0, remainder < bv}, 1);
    end
    @(posedge clk); #1;
    chk("done_pulse_end", {31'b0, done}, 0);
  endtask

  initial begin
    int lat, bc, hi;
    logic [15:0] ra;
    logic [7:0]  rb;

    #1;
    chk("rst_quotient", {24'b0, quotient}, 0);
    chk("rst_remainder", {24'b0, remainder}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    @(negedge clk);
    rst = 1'b1;

    div_and_check(16'd1000, 8'd7, 1'b1);
    div_and_check(16'hFEFF, 8'hFF, 1'b1);
    div_and_check(16'd50, 8'd0, 1'b1);
    div_and_check(16'd50, 8'd5, 1'b1);
    div_and_check(16'h0A00, 8'h0A, 1'b1);

    // Abort in the 4th CALC cycle.
    @(negedge clk);
    a = 16'd1000; b = 8'd7; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_quotient", {24'b0, quotient}, 0);
    chk("abort_remainder", {24'b0, remainder}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_err", {31'b0, err}, 0);
    lat = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) lat++;
    end
    chk("abort_no_done", lat, 0);
    @(negedge clk);
    rst = 1'b1;
    div_and_check(16'd12345, 8'd99, 1'b1);

    // A second start while busy must not disturb the running division.
    @(negedge clk);
    a = 16'd1000; b = 8'd7; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    @(negedge clk);
    a = 16'd500; b = 8'd3; st = 1'b1;
    @(negedge clk);
    st = 1'b0; a = 16'd9; b = 8'd2;
    lat = 2;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_st_latency", lat, 9);
    chk("busy_st_quotient", {24'b0, quotient}, 142);
    chk("busy_st_remainder", {24'b0, remainder}, 6);
    chk("busy_st_err", {31'b0, err}, 0);
    @(posedge clk); #1;
    chk("busy_st_idle", {31'b0, busy}, 0);

    for (int i = 0; i < 1000; i++) begin
      rb = 8'($urandom_range(0, 255));
      if (rb != 0 && ($urandom_range(0, 3) != 0)) hi = $urandom_range(0, int'(rb) - 1);
      else hi = $urandom_range(0, 255);
      ra = {8'(hi), 8'($urandom_range(0, 255))};
      div_and_check(ra, rb, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
